// File: rtl/csa_seq_ctrl.sv
// Sequential WIDTH-bit adder built on one shared 4-bit carry-select slice.
// One slice per cycle, LSB first, carry held in a register between slices.
module csa_seq_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int NSLICE = WIDTH / 4;
  localparam int IW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IW-1:0] LAST = IW'(NSLICE - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic [31:0]      sh;
  logic [3:0]       sa, sb, ss;
  logic             sc;
  logic [2:0]       lo, hi0, hi1;

  // Upper half is precomputed for both carries; the low half picks one.
  always_comb begin
    sh  = 32'(idx_q) << 2;
    sa  = 4'(a_q >> sh);
    sb  = 4'(b_q >> sh);
    lo  = {1'b0, sa[1:0]} + {1'b0, sb[1:0]} + {2'b0, carry_q};
    hi0 = {1'b0, sa[3:2]} + {1'b0, sb[3:2]};
    hi1 = hi0 + 3'd1;
    ss  = {(lo[2] ? hi1[1:0] : hi0[1:0]), lo[1:0]};
    sc  = lo[2] ? hi1[2] : hi0[2];
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d   = (sum_q & ~(WIDTH'(4'hF) << sh))
                | (WIDTH'(ss) << sh);
        carry_d = sc;
        if (idx_q == LAST) begin
          cout_d  = sc;
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN) || (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_csa_seq_ctrl.sv
// Scoreboard bench for csa_seq_ctrl: 16-bit instance for the main flow,
// 4-bit instance for the single-slice case after a mid-run reset.
module tb_csa_seq_ctrl;

  typedef struct packed {
    logic        c;
    logic [15:0] s;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, out_ready, cin;
  logic [15:0] a, b;
  logic        in_ready, out_valid, cout, busy;
  logic [15:0] sum;

  logic        in_valid4, cin4;
  logic        out_ready4;
  logic [3:0]  a4, b4;
  logic        in_ready4, out_valid4, cout4, busy4;
  logic [3:0]  sum4;

  res_t        sb[$];
  res_t        e;
  int          n_chk = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  csa_seq_ctrl #(.WIDTH(16)) u16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .busy(busy)
  );

  csa_seq_ctrl #(.WIDTH(4)) u4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .cin(cin4),
    .out_valid(out_valid4), .out_ready(out_ready4),
    .sum(sum4), .cout(cout4), .busy(busy4)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h exp %0h", tag, got, exp);
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("sum", 32'(sum), 32'(e.s));
        chk("cout", 32'(cout), 32'(e.c));
      end
    end
  end

  task automatic run_op(input logic [15:0] ta,
                        input logic [15:0] tb,
                        input logic        tc);
    int   w;
    int   lat;
    res_t r;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("in_ready_wait", 32'(in_ready), 32'd1);
    a = ta;
    b = tb;
    cin = tc;
    in_valid = 1'b1;
    {r.c, r.s} = 17'(ta) + 17'(tb) + 17'(tc);
    sb.push_back(r);
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
    chk("latency", 32'(lat), 32'd4);
    if (out_ready) begin
      @(posedge clk);
      #1 chk("ov_one_cycle", 32'(out_valid), 32'd0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = '0;
    b = '0;
    cin = 1'b0;
    in_valid4 = 1'b0;
    out_ready4 = 1'b1;
    a4 = '0;
    b4 = '0;
    cin4 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);

    run_op(16'h0000, 16'h0000, 1'b0);
    run_op(16'h0005, 16'h0003, 1'b1);
    run_op(16'hFFFF, 16'h0001, 1'b0);
    run_op(16'hFFFF, 16'hFFFF, 1'b1);
    run_op(16'hA5A5, 16'h5A5A, 1'b1);
    for (int i = 0; i < 6; i++) begin
      run_op(16'($urandom), 16'($urandom), 1'($urandom));
    end

    // Back-pressure: result held, new operands ignored.
    out_ready = 1'b0;
    run_op(16'h9234, 16'h8111, 1'b1);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      in_valid = (i % 2 == 0);
      a = 16'hDEAD;
      b = 16'hBEEF;
      cin = 1'b1;
      chk("hold_ov", 32'(out_valid), 32'd1);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_sum", 32'(sum), 32'h1346);
      chk("hold_cout", 32'(cout), 32'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_in_ready", 32'(in_ready), 32'd1);
    chk("rel_ov", 32'(out_valid), 32'd0);
    run_op(16'h0F0F, 16'h00F1, 1'b0);

    // Reset during the second RUN cycle abandons the op.
    @(negedge clk);
    a = 16'h1234;
    b = 16'h4321;
    cin = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk("run_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("ar_ov", 32'(out_valid), 32'd0);
    chk("ar_sum", 32'(sum), 32'd0);
    chk("ar_cout", 32'(cout), 32'd0);
    chk("ar_busy", 32'(busy), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ar_in_ready", 32'(in_ready), 32'd1);
    chk("ar_ov_stay", 32'(out_valid), 32'd0);

    // Single-slice build.
    @(negedge clk);
    a4 = 4'hF;
    b4 = 4'h1;
    cin4 = 1'b0;
    in_valid4 = 1'b1;
    @(posedge clk);
    #1 in_valid4 = 1'b0;
    chk("w4_busy", 32'(busy4), 32'd1);
    chk("w4_ov_early", 32'(out_valid4), 32'd0);
    @(posedge clk);
    #1;
    chk("w4_ov", 32'(out_valid4), 32'd1);
    chk("w4_sum", 32'(sum4), 32'h0);
    chk("w4_cout", 32'(cout4), 32'd1);
    @(posedge clk);
    #1;
    chk("w4_ov_drop", 32'(out_valid4), 32'd0);
    chk("w4_in_ready", 32'(in_ready4), 32'd1);

    repeat (2) @(posedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
